gpu_sram_arbiter: RTL and testbench
===================================

GPU_SRAM_ARBITER -- requirements
Module: gpu_sram_arbiter

Interface
REQ-001 The block SHALL have one parameter: BURST_MAX, default 4, the maximum number of consecutive accepted transactions for one requester while the other requester is waiting (round-robin mode only).
REQ-002 The block SHALL use one clock, I_CLK, and an asynchronous active-low reset, I_RST_N.
REQ-003 Ports, one per line (name  direction  width  meaning):
- I_CLK  in  1  clock.
- I_RST_N  in  1  async active-low reset.
- I_VIDEO_ON  in  1  high = display scan owns the SRAM; no GPU access is allowed.
- I_REQ0_VALID / I_REQ1_VALID  in  1  request present (0 = draw engine, 1 = clear engine).
- I_REQ0_WE / I_REQ1_WE  in  1  1 = write, 0 = read.
- I_REQ0_ADDR / I_REQ1_ADDR  in  18  pixel address.
- I_REQ0_DATA / I_REQ1_DATA  in  16  write data.
- O_REQ0_READY / O_REQ1_READY  out  1  request accepted this cycle when VALID is also high.
- O_RD_VALID0 / O_RD_VALID1  out  1  one-cycle read-return strobe.
- O_RD_DATA  out  16  read-return data.
- I_GPU_DATA  in  16  SRAM read data.
- O_GPU_DATA  out  16  SRAM write data (registered).
- O_GPU_ADDR  out  18  SRAM address (registered).
- O_GPU_WRITE  out  1  SRAM write strobe (registered).
- O_GPU_READ  out  1  SRAM read strobe (registered).
- O_OWNER  out  1  index of the requester granted most recently.

Function
REQ-004 O_REQx_READY SHALL be combinational: it is high only when I_VIDEO_ON=0 and the arbiter selects requester x. At most one READY SHALL be high in any cycle.
REQ-005 A transaction SHALL be accepted on the rising edge where VALID and READY are both high. On the next cycle the block drives ADDR/DATA/WE onto O_GPU_ADDR/O_GPU_DATA and sets exactly one of O_GPU_WRITE/O_GPU_READ high, for one cycle.
REQ-006 In any cycle with no accepted transaction on the prior edge, O_GPU_WRITE=0 and O_GPU_READ=0. O_GPU_ADDR and O_GPU_DATA SHALL hold their last values.
REQ-007 Read return:
- I_GPU_DATA SHALL be sampled on the edge ending the O_GPU_READ cycle.
- O_RD_DATA and O_RD_VALIDx SHALL then be presented for one cycle, 2 cycles after acceptance.
- x is the requester that issued the read.
REQ-008 Back-to-back acceptance every cycle SHALL be supported. The read-return pipeline SHALL be 2 stages deep and never stall.
REQ-009 The FSM SHALL have three states:
- BLANK: I_VIDEO_ON=1; no READY.
- IDLE: no VALID.
- SERVE: a grant is active.
Transitions are evaluated every cycle; I_VIDEO_ON=1 forces BLANK from any state.
REQ-010 If I_VIDEO_ON rises, READY SHALL drop in the same cycle. A transaction accepted on the previous edge SHALL still complete, including its read return.
REQ-011 Burst counter:
- Counts consecutive acceptances by O_OWNER; width is clog2(BURST_MAX+1).
- Clears on an owner change, in IDLE, and in BLANK.
- Saturates at BURST_MAX.
REQ-012 Simultaneous VALID from both requesters SHALL resolve per the Configuration section. A lone VALID SHALL always be granted when I_VIDEO_ON=0.
REQ-013 O_OWNER SHALL update on each acceptance and hold otherwise.

Reset
REQ-014 When I_RST_N=0, asynchronously:
- O_GPU_ADDR=0, O_GPU_DATA=0.
- O_GPU_WRITE=0, O_GPU_READ=0.
- O_RD_VALID0=0, O_RD_VALID1=0, O_RD_DATA=0.
- O_OWNER=0, burst counter=0, FSM=IDLE.
REQ-015 Reset mid-transaction SHALL discard all in-flight reads. No O_RD_VALIDx SHALL follow reset release unless a new read is accepted.
REQ-016 READY SHALL be 0 while I_RST_N=0.

Configuration
REQ-017 With macro GPU_ARB_ROUND_ROBIN_EN defined, round-robin arbitration SHALL apply:
- On contention the non-owner wins if the owner's burst count equals BURST_MAX.
- Otherwise the owner keeps the grant.
- From IDLE or BLANK with contention, the requester other than O_OWNER wins.
REQ-018 Without GPU_ARB_ROUND_ROBIN_EN, fixed priority SHALL apply: requester 0 always wins on contention. BURST_MAX is then unused and the counter SHALL be removed.

Verification
REQ-019 Lone write: REQ0 valid, WE=1, ADDR=0x00100, DATA=0xF0F0, VIDEO_ON=0 -> READY0 high the same cycle; next cycle O_GPU_WRITE=1, O_GPU_ADDR=0x00100, O_GPU_DATA=0xF0F0.
REQ-020 Read: REQ1 read, ADDR=0x3FFFF; SRAM returns 0x1234 during the O_GPU_READ cycle -> O_RD_VALID1=1 and O_RD_DATA=0x1234 exactly 2 cycles after acceptance; O_RD_VALID0 stays 0.
REQ-021 Blanking: VIDEO_ON rises the cycle after an accept -> that access still strobes; both READY lines stay 0 until VIDEO_ON=0.
REQ-022 Round-robin contention (macro defined, BURST_MAX=4): both VALID held for 10 cycles -> grants 0,0,0,0,1,1,1,1,0,0. Fixed priority (no macro) -> 10 grants to 0.
REQ-023 Reset asserted one cycle after a read accept -> O_GPU_READ=0 immediately; no O_RD_VALIDx after release.

Source files
------------

// File: rtl/gpu_sram_arbiter.sv
// Two-requester SRAM arbiter for the GPU draw/clear engines, yielding to display scan.
// Define GPU_ARB_ROUND_ROBIN_EN for burst-limited round-robin; otherwise requester 0 has fixed priority.
module gpu_sram_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic        I_CLK,
  input  logic        I_RST_N,
  input  logic        I_VIDEO_ON,
  input  logic        I_REQ0_VALID,
  input  logic        I_REQ0_WE,
  input  logic [17:0] I_REQ0_ADDR,
  input  logic [15:0] I_REQ0_DATA,
  input  logic        I_REQ1_VALID,
  input  logic        I_REQ1_WE,
  input  logic [17:0] I_REQ1_ADDR,
  input  logic [15:0] I_REQ1_DATA,
  output logic        O_REQ0_READY,
  output logic        O_REQ1_READY,
  output logic        O_RD_VALID0,
  output logic        O_RD_VALID1,
  output logic [15:0] O_RD_DATA,
  input  logic [15:0] I_GPU_DATA,
  output logic [15:0] O_GPU_DATA,
  output logic [17:0] O_GPU_ADDR,
  output logic        O_GPU_WRITE,
  output logic        O_GPU_READ,
  output logic        O_OWNER
);

  // state | meaning
  // IDLE  | no request pending
  // SERVE | a grant is active
  // BLANK | display scan owns the SRAM, no READY
  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_BLANK} state_t;

  state_t state;
  logic   arb_en;
  logic   any_valid;
  logic   both_valid;
  logic   sel;
  logic   accept;
  logic   sel_we;

  assign arb_en     = I_RST_N & ~I_VIDEO_ON;
  assign any_valid  = I_REQ0_VALID | I_REQ1_VALID;
  assign both_valid = I_REQ0_VALID & I_REQ1_VALID;

`ifdef GPU_ARB_ROUND_ROBIN_EN
  localparam int CW = $clog2(BURST_MAX + 1);
  logic [CW-1:0] burst_cnt;

  always_comb begin
    sel = I_REQ1_VALID;
    if (both_valid) begin
      if (state != S_SERVE)
        sel = ~O_OWNER;
      else if (burst_cnt == CW'(BURST_MAX))
        sel = ~O_OWNER;
      else
        sel = O_OWNER;
    end
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      burst_cnt <= '0;
    end else if (I_VIDEO_ON || !any_valid) begin
      burst_cnt <= '0;
    end else if (accept) begin
      if (sel != O_OWNER)
        burst_cnt <= CW'(1);
      else if (burst_cnt != CW'(BURST_MAX))
        burst_cnt <= burst_cnt + CW'(1);
    end
  end
`else
  // Fixed priority needs neither the burst limit nor the FSM state for selection.
  localparam int unused_burst_max = BURST_MAX;
  logic unused_state;
  assign unused_state = ^state;

  always_comb begin
    sel = I_REQ1_VALID & ~I_REQ0_VALID;
  end
`endif

  assign O_REQ0_READY = arb_en & I_REQ0_VALID & ~sel;
  assign O_REQ1_READY = arb_en & I_REQ1_VALID & sel;
  assign accept       = O_REQ0_READY | O_REQ1_READY;
  assign sel_we       = sel ? I_REQ1_WE : I_REQ0_WE;

  // O_OWNER doubles as the read-return tag: it is updated on the same edge that launches O_GPU_READ.
  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state       <= S_IDLE;
      O_OWNER     <= 1'b0;
      O_GPU_ADDR  <= '0;
      O_GPU_DATA  <= '0;
      O_GPU_WRITE <= 1'b0;
      O_GPU_READ  <= 1'b0;
      O_RD_VALID0 <= 1'b0;
      O_RD_VALID1 <= 1'b0;
      O_RD_DATA   <= '0;
    end else begin
      if (I_VIDEO_ON)
        state <= S_BLANK;
      else if (any_valid)
        state <= S_SERVE;
      else
        state <= S_IDLE;

      O_GPU_WRITE <= accept & sel_we;
      O_GPU_READ  <= accept & ~sel_we;
      if (accept) begin
        O_OWNER    <= sel;
        O_GPU_ADDR <= sel ? I_REQ1_ADDR : I_REQ0_ADDR;
        O_GPU_DATA <= sel ? I_REQ1_DATA : I_REQ0_DATA;
      end

      O_RD_VALID0 <= O_GPU_READ & ~O_OWNER;
      O_RD_VALID1 <= O_GPU_READ & O_OWNER;
      if (O_GPU_READ)
        O_RD_DATA <= I_GPU_DATA;
    end
  end

endmodule

// File: tb/tb_gpu_sram_arbiter.sv
// Directed bench for gpu_sram_arbiter; contention expectations follow GPU_ARB_ROUND_ROBIN_EN.
module tb_gpu_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        video_on;
  logic        v0, we0, v1, we1;
  logic [17:0] a0, a1;
  logic [15:0] d0, d1;
  logic        rdy0, rdy1, rv0, rv1;
  logic [15:0] rd_data, gpu_din, gpu_dout;
  logic [17:0] gpu_addr;
  logic        gpu_wr, gpu_rd, owner;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gpu_sram_arbiter #(.BURST_MAX(4)) dut (
    .I_CLK(clk), .I_RST_N(rst_n), .I_VIDEO_ON(video_on),
    .I_REQ0_VALID(v0), .I_REQ0_WE(we0), .I_REQ0_ADDR(a0), .I_REQ0_DATA(d0),
    .I_REQ1_VALID(v1), .I_REQ1_WE(we1), .I_REQ1_ADDR(a1), .I_REQ1_DATA(d1),
    .O_REQ0_READY(rdy0), .O_REQ1_READY(rdy1),
    .O_RD_VALID0(rv0), .O_RD_VALID1(rv1), .O_RD_DATA(rd_data),
    .I_GPU_DATA(gpu_din), .O_GPU_DATA(gpu_dout), .O_GPU_ADDR(gpu_addr),
    .O_GPU_WRITE(gpu_wr), .O_GPU_READ(gpu_rd), .O_OWNER(owner)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] grant1_exp;

  initial begin
`ifdef GPU_ARB_ROUND_ROBIN_EN
    grant1_exp = 10'b0011110000;  // bit i = requester 1 expected on grant i
`else
    grant1_exp = 10'b0000000000;
`endif
    rst_n = 1'b0; video_on = 1'b0;
    v0 = 1'b1; we0 = 1'b0; a0 = '0; d0 = '0;
    v1 = 1'b0; we1 = 1'b0; a1 = '0; d1 = '0;
    gpu_din = '0;
    #3;
    check("rst_ready0", 32'(rdy0), 32'd0);
    check("rst_write", 32'(gpu_wr), 32'd0);
    check("rst_read", 32'(gpu_rd), 32'd0);
    check("rst_addr", 32'(gpu_addr), 32'd0);
    check("rst_data", 32'(gpu_dout), 32'd0);
    check("rst_rdvalid", 32'({rv1, rv0}), 32'd0);
    check("rst_rddata", 32'(rd_data), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    v0 = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // lone write from requester 0
    v0 = 1'b1; we0 = 1'b1; a0 = 18'h00100; d0 = 16'hF0F0;
    #1;
    check("wr_ready0", 32'(rdy0), 32'd1);
    check("wr_ready1", 32'(rdy1), 32'd0);
    tick();
    v0 = 1'b0;
    check("wr_strobe", 32'(gpu_wr), 32'd1);
    check("wr_no_read", 32'(gpu_rd), 32'd0);
    check("wr_addr", 32'(gpu_addr), 32'h00100);
    check("wr_data", 32'(gpu_dout), 32'hF0F0);
    check("wr_owner", 32'(owner), 32'd0);
    tick();
    check("wr_strobe_drop", 32'(gpu_wr), 32'd0);
    check("wr_addr_hold", 32'(gpu_addr), 32'h00100);

    // read from requester 1 at the top address
    v1 = 1'b1; we1 = 1'b0; a1 = 18'h3FFFF; d1 = 16'h0000;
    #1;
    check("rd_ready1", 32'(rdy1), 32'd1);
    tick();
    v1 = 1'b0; gpu_din = 16'h1234;
    check("rd_strobe", 32'(gpu_rd), 32'd1);
    check("rd_addr", 32'(gpu_addr), 32'h3FFFF);
    check("rd_owner", 32'(owner), 32'd1);
    check("rd_not_yet", 32'({rv1, rv0}), 32'd0);
    tick();
    gpu_din = 16'h0000;
    check("rd_valid1", 32'(rv1), 32'd1);
    check("rd_valid0", 32'(rv0), 32'd0);
    check("rd_data", 32'(rd_data), 32'h1234);
    check("rd_strobe_drop", 32'(gpu_rd), 32'd0);
    tick();
    check("rd_valid_pulse", 32'({rv1, rv0}), 32'd0);

    // contention for 10 cycles, coming from IDLE with owner=1
    v0 = 1'b1; we0 = 1'b1; a0 = 18'h00010; d0 = 16'h0A0A;
    v1 = 1'b1; we1 = 1'b1; a1 = 18'h00020; d1 = 16'h0B0B;
    for (int i = 0; i < 10; i++) begin
      #1;
      check($sformatf("cont_rdy1_%0d", i), 32'(rdy1), 32'(grant1_exp[i]));
      check($sformatf("cont_rdy0_%0d", i), 32'(rdy0), 32'(!grant1_exp[i]));
      tick();
    end
    v0 = 1'b0; v1 = 1'b0;
    check("cont_owner", 32'(owner), 32'd0);
    check("cont_last_addr", 32'(gpu_addr), 32'h00010);
    tick();

    // blanking one cycle after an accept
    v0 = 1'b1; we0 = 1'b1; a0 = 18'h00055; d0 = 16'hAAAA;
    #1;
    check("blk_ready0_pre", 32'(rdy0), 32'd1);
    tick();
    video_on = 1'b1;
    #1;
    check("blk_ready_drop", 32'({rdy1, rdy0}), 32'd0);
    check("blk_strobe", 32'(gpu_wr), 32'd1);
    check("blk_addr", 32'(gpu_addr), 32'h00055);
    tick();
    v1 = 1'b1;
    #1;
    check("blk_no_strobe", 32'(gpu_wr), 32'd0);
    check("blk_ready_held", 32'({rdy1, rdy0}), 32'd0);
    tick();
    check("blk_ready_held2", 32'({rdy1, rdy0}), 32'd0);
    v1 = 1'b0; video_on = 1'b0;
    #1;
    check("blk_ready_back", 32'(rdy0), 32'd1);
    v0 = 1'b0;
    tick();
    tick();

    // reset one cycle after a read accept
    v0 = 1'b1; we0 = 1'b0; a0 = 18'h00077;
    tick();
    v0 = 1'b0; gpu_din = 16'hBEEF;
    check("rst_rd_strobe", 32'(gpu_rd), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_rd_kill", 32'(gpu_rd), 32'd0);
    v0 = 1'b1;
    #1;
    check("rst_ready_low", 32'(rdy0), 32'd0);
    v0 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_no_rdvalid_%0d", i), 32'({rv1, rv0}), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
